// File: rtl/md_unit_pkg.sv
// ----------------------------------------------------------------------------
// md_unit_pkg
//   Shared definitions for the EX-stage multiply/divide unit: the 3-bit MD
//   operation encodings, the FSM state type, default latencies and the
//   combinational arithmetic helper that produces the 64-bit {hi,lo} result.
//
//   Exports:
//     MD_MULT/MD_MULTU/MD_DIV/MD_DIVU/MD_MTHI/MD_MTLO   operation encodings
//     md_state_t                                       IDLE / RUN state type
//     MD_DEFAULT_MULT_CYCLES, MD_DEFAULT_DIV_CYCLES    default latencies
//     md_is_arith(op), md_is_div(op)                   op classification
//     md_compute(op, a, b)                             {hi,lo} result
// ----------------------------------------------------------------------------
package md_unit_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    localparam int MD_DEFAULT_MULT_CYCLES = 5;
    localparam int MD_DEFAULT_DIV_CYCLES  = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_t;

    // True for the four ops that occupy the unit for a multi-cycle latency.
    function automatic logic md_is_arith(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) ||
               (op == MD_DIV)  || (op == MD_DIVU);
    endfunction

    function automatic logic md_is_div(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    // Returns {hi, lo}. Signed division works on magnitudes and then fixes
    // the signs, so the quotient truncates toward zero and the remainder
    // follows the dividend. The 0x8000_0000 / -1 overflow case falls out of
    // this naturally: magnitude quotient 0x8000_0000 negates to itself and
    // the remainder is zero. Divide by zero returns lo=all-ones, hi=dividend.
    function automatic logic [63:0] md_compute(input logic [2:0]  op,
                                               input logic [31:0] a,
                                               input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic signed [63:0] sprod;
        logic        [63:0] ua;
        logic        [63:0] ub;
        logic        [31:0] mag_a;
        logic        [31:0] mag_b;
        logic        [31:0] q;
        logic        [31:0] rm;
        logic        [63:0] r;

        sa    = {{32{a[31]}}, a};
        sb    = {{32{b[31]}}, b};
        sprod = sa * sb;
        ua    = {32'd0, a};
        ub    = {32'd0, b};
        mag_a = a[31] ? (~a + 32'd1) : a;
        mag_b = b[31] ? (~b + 32'd1) : b;
        q     = 32'd0;
        rm    = 32'd0;
        r     = 64'd0;

        case (op)
            MD_MULT:  r = sprod;
            MD_MULTU: r = ua * ub;
            MD_DIV: begin
                if (b == 32'd0) begin
                    r = {a, 32'hFFFF_FFFF};
                end else begin
                    q  = mag_a / mag_b;
                    rm = mag_a % mag_b;
                    if (a[31] ^ b[31]) q  = ~q + 32'd1;
                    if (a[31])         rm = ~rm + 32'd1;
                    r = {rm, q};
                end
            end
            MD_DIVU: begin
                if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
                else            r = {a % b, a / b};
            end
            default:  r = 64'd0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/md_unit.sv
// ----------------------------------------------------------------------------
// md_unit
//   Multi-cycle multiply/divide unit in the EX stage. Executes MULT, MULTU,
//   DIV and DIVU with a fixed latency set by a down-counter, owns the HI/LO
//   registers and also services MTHI/MTLO in a single cycle. The ID-stage
//   hazard unit watches busy and stalls MD-class instructions while it is set.
//
//   Parameters:
//     MULT_CYCLES  cycles from start to HI/LO update for MULT/MULTU (>=1)
//     DIV_CYCLES   cycles from start to HI/LO update for DIV/DIVU (>=1)
//
//   Ports:
//     clk    in   1   rising-edge clock
//     reset  in   1   asynchronous, active-low reset
//     start  in   1   issue strobe; mdop/A/B valid this cycle
//     mdop   in   3   MD operation (see md_unit_pkg)
//     A      in   32  rs operand
//     B      in   32  rt operand
//     flush  in   1   abort in-flight op / drop a same-cycle start
//     busy   out  1   op in flight, HI/LO not yet final
//     hi     out  32  HI register
//     lo     out  32  LO register
// ----------------------------------------------------------------------------
module md_unit
    import md_unit_pkg::*;
#(
    parameter int MULT_CYCLES = MD_DEFAULT_MULT_CYCLES,
    parameter int DIV_CYCLES  = MD_DEFAULT_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  mdop,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        flush,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    md_state_t   state;
    logic [15:0] cnt;
    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic [63:0] result;
    logic        accept;

    // The arithmetic itself is purely combinational; the counter below only
    // models the latency the hazard unit has to respect. A start is taken
    // only from IDLE and only when no flush arrives in the same cycle.
    always_comb begin
        result = md_compute(mdop, A, B);
        accept = (state == ST_IDLE) && start && !flush;
    end

    // Single FSM holding all architectural state. The result is latched at
    // issue and only committed to hi/lo on the final counted edge, so a flush
    // at any point of RUN (including the commit edge) leaves hi/lo at their
    // pre-op values. Starts arriving in RUN are ignored.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ST_IDLE;
            cnt    <= 16'd0;
            busy   <= 1'b0;
            hi     <= 32'd0;
            lo     <= 32'd0;
            res_hi <= 32'd0;
            res_lo <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (md_is_arith(mdop)) begin
                            res_hi <= result[63:32];
                            res_lo <= result[31:0];
                            cnt    <= md_is_div(mdop) ? 16'(DIV_CYCLES - 1)
                                                      : 16'(MULT_CYCLES - 1);
                            busy   <= 1'b1;
                            state  <= ST_RUN;
                        end else if (mdop == MD_MTHI) begin
                            hi <= A;
                        end else if (mdop == MD_MTLO) begin
                            lo <= A;
                        end
                    end
                end
                ST_RUN: begin
                    if (flush) begin
                        busy  <= 1'b0;
                        cnt   <= 16'd0;
                        state <= ST_IDLE;
                    end else if (cnt == 16'd0) begin
                        hi    <= res_hi;
                        lo    <= res_lo;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    cnt   <= 16'd0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
